cute_key_sequencer: RTL and testbench

Key-delivery sequencer for time-windowed locked FSMs in the Cute-Lock benchmark flow. It stores the per-window unlock keys, mirrors the locked block's free-running window counter, and drives the locked block's `keyinput` bus with the key for the current window. It sits beside a locked FSM and shares its `clk` and `rst`, so both counters stay phase-aligned from reset.

---
 rtl/cute_key_sequencer.sv | 109 ++++++++++
 tb/tb_cute_key_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cute_key_sequencer.sv
// Key-delivery sequencer for time-windowed locked FSMs. Mirrors the locked block's window
// counter on negedge and presents the current window's key on posedge. Optional macro: KEYSEQ_SCRUB_EN.
module cute_key_sequencer #(
   parameter int KEY_W    = 10,
   parameter int NUM_KEYS = 3,
   parameter int WIN_LEN  = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_idx,
   input  logic [KEY_W-1:0] cfg_key,
   input  logic             arm,
   output logic [KEY_W-1:0] key_out,
   output logic [1:0]       win_idx,
   output logic [5:0]       cnt,
   output logic             armed,
   output logic             cfg_err
);

   localparam int         PERIOD     = NUM_KEYS * WIN_LEN;
   localparam logic [5:0] CNT_LAST   = 6'(PERIOD - 1);
   localparam logic [5:0] WIN_LEN_C  = 6'(WIN_LEN);
   localparam logic [2:0] NUM_KEYS_C = 3'(NUM_KEYS);
   localparam logic [3:0] MASK_FULL  = 4'((1 << NUM_KEYS) - 1);

   typedef enum logic [1:0] {UNPROG, READY, RUN} state_t;

   state_t           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [1:0]       win_q, win_d;
   logic             armed_q, armed_d;
   logic             err_q, err_d;
   logic [3:0]       mask_q, mask_d;
   logic [KEY_W-1:0] key_q [4];
   logic [KEY_W-1:0] key_d [4];
   logic [KEY_W-1:0] key_out_q, key_out_d;
   logic             idx_ok, wr_ok;

   always_comb begin
      cnt_d  = (cnt_q >= CNT_LAST) ? 6'd0 : cnt_q + 6'd1;
      win_d  = 2'(cnt_d / WIN_LEN_C);
      idx_ok = ({1'b0, cfg_idx} < NUM_KEYS_C);
      wr_ok  = cfg_we && idx_ok && (state_q != RUN);
      err_d  = cfg_we && !wr_ok;

      key_d  = key_q;
      mask_d = mask_q;
      if (wr_ok) begin
         key_d[cfg_idx]  = cfg_key;
         mask_d[cfg_idx] = 1'b1;
      end

      // The mask is compared exactly so a stray bit can never unlock READY.
      state_d = state_q;
      case (state_q)
         UNPROG: if (mask_q == MASK_FULL) state_d = READY;
         READY:  if (arm) state_d = RUN;
         RUN: begin
            if (!arm) begin
`ifdef KEYSEQ_SCRUB_EN
               state_d = UNPROG;
               mask_d  = '0;
               for (int i = 0; i < 4; i++) key_d[i] = '0;
`else
               state_d = READY;
`endif
            end
         end
         default: state_d = UNPROG;
      endcase
      armed_d = (state_d == RUN);

      key_out_d = (state_q == RUN) ? key_q[win_q] : '0;
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q <= UNPROG;
         cnt_q   <= '0;
         win_q   <= '0;
         armed_q <= 1'b0;
         err_q   <= 1'b0;
         mask_q  <= '0;
         for (int i = 0; i < 4; i++) key_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         armed_q <= armed_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         for (int i = 0; i < 4; i++) key_q[i] <= key_d[i];
      end
   end

   // Posedge launch keeps key_out stable around the locked block's negedge sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) key_out_q <= '0;
      else     key_out_q <= key_out_d;
   end

   assign key_out = key_out_q;
   assign win_idx = win_q;
   assign cnt     = cnt_q;
   assign armed   = armed_q;
   assign cfg_err = err_q;

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Scoreboard bench for cute_key_sequencer: driver queues expected outputs per cycle,
// monitor compares them one posedge later. Honors KEYSEQ_SCRUB_EN when defined.
module tb_cute_key_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_idx = 2'd0;
   logic [9:0] cfg_key = 10'd0;
   logic       arm = 1'b0;
   logic [9:0] key_out;
   logic [1:0] win_idx;
   logic [5:0] cnt;
   logic       armed;
   logic       cfg_err;

   typedef struct {
      logic [9:0] key;
      logic [5:0] cnt;
      logic [1:0] win;
      logic       armed;
      logic       err;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_cnt = 0;

   cute_key_sequencer dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
      .arm(arm), .key_out(key_out), .win_idx(win_idx), .cnt(cnt), .armed(armed),
      .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic int key_for(input int c);
      if (c < 7)       return 18;
      else if (c < 14) return 382;
      else             return 958;
   endfunction

   function automatic int nxt(input int c);
      return (c >= 20) ? 0 : c + 1;
   endfunction

   // Called just after a posedge; inputs are sampled at the following negedge.
   task automatic step(input logic a, input logic w, input logic [1:0] i, input logic [9:0] k,
                       input logic ea, input logic ee);
      exp_t e;
      arm = a; cfg_we = w; cfg_idx = i; cfg_key = k;
      exp_cnt = nxt(exp_cnt);
      e.key   = ea ? 10'(key_for(exp_cnt)) : 10'd0;
      e.cnt   = 6'(exp_cnt);
      e.win   = 2'(exp_cnt / 7);
      e.armed = ea;
      e.err   = ee;
      q.push_back(e);
      @(posedge clk); #2;
   endtask

   task automatic load3();
      step(1'b0, 1'b1, 2'd0, 10'd18,  1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd1, 10'd382, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd2, 10'd958, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("key_out", int'(key_out), int'(mon_e.key));
            chk("cnt",     int'(cnt),     int'(mon_e.cnt));
            chk("win_idx", int'(win_idx), int'(mon_e.win));
            chk("armed",   int'(armed),   int'(mon_e.armed));
            chk("cfg_err", int'(cfg_err), int'(mon_e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, n_bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_key_out", int'(key_out), 0);
      chk("rst_cnt",     int'(cnt),     0);
      chk("rst_win_idx", int'(win_idx), 0);
      chk("rst_armed",   int'(armed),   0);
      chk("rst_cfg_err", int'(cfg_err), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      exp_cnt = 0;

      // Partial load plus an out-of-range write: arming must be ignored.
      step(1'b0, 1'b1, 2'd0, 10'd18,  1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd1, 10'd382, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd3, 10'd77,  1'b0, 1'b1);
      for (int n = 0; n < 42; n++) step(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 1'b0);

      // Complete the load; arm so RUN begins exactly at cnt=0.
      step(1'b0, 1'b1, 2'd2, 10'd958, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0);
      while (nxt(exp_cnt) != 0) step(1'b0, 1'b0, 2'd0, 10'd0, 1'b0, 1'b0);
      for (int n = 0; n < 42; n++) begin
         logic w;
         w = (n < 21) && (nxt(exp_cnt) == 8);
         step(1'b1, w, 2'd1, 10'd5, 1'b1, w);
      end

      // Disarm, then re-arm mid-period at cnt=10.
      step(1'b0, 1'b0, 2'd0, 10'd0, 1'b0, 1'b0);
`ifdef KEYSEQ_SCRUB_EN
      for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 1'b0);
      load3();
`endif
      while (nxt(exp_cnt) != 10) step(1'b0, 1'b0, 2'd0, 10'd0, 1'b0, 1'b0);
      while (exp_cnt != 15) step(1'b1, 1'b0, 2'd0, 10'd0, 1'b1, 1'b0);

      // Asynchronous reset in RUN at cnt=15.
      rst = 1'b1;
      #1;
      chk("midrst_key_out", int'(key_out), 0);
      chk("midrst_cnt",     int'(cnt),     0);
      chk("midrst_armed",   int'(armed),   0);
      chk("midrst_win_idx", int'(win_idx), 0);
      @(posedge clk); #2 rst = 1'b0;
      exp_cnt = 0;
      for (int n = 0; n < 25; n++) step(1'b1, 1'b0, 2'd0, 10'd0, 1'b0, 1'b0);

      @(posedge clk); #2;
      chk("queue_drain", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
